// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port, 1-cycle-latency SRAM macro
// among NUM_PORTS requesters. After reset an optional sequencer zeroes the
// whole array before any requester is served.
module sram_rr_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_WORDS     = 1024,
    parameter int INIT_ON_RESET = 1,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*AW-1:0]         addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_PORTS*BW-1:0]         be_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            init_done_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [AW-1:0]                   sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_wdata_o,
    output logic [BW-1:0]                   sram_be_o,
    input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {ST_START, ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic                  we;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BW-1:0]         be;
    } port_req_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                cnt_q;
    logic [PW-1:0]                ptr_q;
    logic [PW-1:0]                gidx;
    logic [PW-1:0]                scan_idx;
    logic                         found;
    logic [NUM_PORTS-1:0]         gnt;
    logic [NUM_PORTS-1:0]         rvalid_q;
    port_req_t [NUM_PORTS-1:0]    preq;
    port_req_t                    sel;

    // Unpack the flat per-port buses into one request struct per port
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign preq[g].we    = we_i[g];
        assign preq[g].addr  = addr_i[g*AW +: AW];
        assign preq[g].wdata = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign preq[g].be    = be_i[g*BW +: BW];
    end

    // Round-robin search: first requester at or above the pointer, with wrap
    always_comb begin
        gnt      = '0;
        gidx     = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
            if (state_q == ST_RUN && !found && req_i[scan_idx]) begin
                found = 1'b1;
                gidx  = scan_idx;
            end
        end
        if (found) gnt[gidx] = 1'b1;
    end

    assign sel = preq[gidx];

    // Next-state logic and macro-side mux (init sweep vs. granted port)
    always_comb begin
        state_d      = state_q;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (state_q)
            ST_START: state_d = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            ST_INIT: begin
                sram_req_o = 1'b1;
                sram_we_o  = 1'b1;
                sram_addr_o = cnt_q;
                sram_be_o  = '1;
                if (cnt_q == AW'(NUM_WORDS - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                sram_req_o   = found;
                sram_we_o    = sel.we;
                sram_addr_o  = sel.addr;
                sram_wdata_o = sel.wdata;
                sram_be_o    = sel.be;
            end
            default: state_d = ST_START;
        endcase
    end

    // State, init counter, RR pointer and response strobe registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_START;
            cnt_q    <= '0;
            ptr_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= gnt;
            if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
            // Pointer moves just past the winner so it has lowest priority next
            if (found) ptr_q <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
        end
    end

    assign gnt_o       = gnt;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = sram_rdata_i;
    assign init_done_o = (state_q == ST_RUN);

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one single-port, 1-cycle-latency SRAM macro (64-bit words, byte enables) among NUM_PORTS requesters using round-robin arbitration.
- After reset, an optional init sequencer zeroes the whole array before any requester is served.
- Sits between cache/controller request ports and the FPGA/ASIC SRAM wrapper.

Parameters:
- NUM_PORTS, 2, number of requesters (>=1).
- DATA_WIDTH, 64, word width in bits.
- NUM_WORDS, 1024, array depth. AW = $clog2(NUM_WORDS), BW = (DATA_WIDTH+7)/8.
- INIT_ON_RESET, 1, 1 = zero the array after reset; 0 = start directly in RUN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NUM_PORTS  per-port request
- we_i  in  NUM_PORTS  per-port write enable
- addr_i  in  NUM_PORTS*AW  per-port address, packed, port i at [i*AW +: AW]
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data, packed
- be_i  in  NUM_PORTS*BW  per-port byte enables, packed
- gnt_o  out  NUM_PORTS  one-hot grant, combinational
- rvalid_o  out  NUM_PORTS  response strobe, one cycle after grant
- rdata_o  out  DATA_WIDTH  read data, shared by all ports
- init_done_o  out  1  array initialised, RUN state
- sram_req_o  out  1  macro request
- sram_we_o  out  1  macro write enable
- sram_addr_o  out  AW  macro address
- sram_wdata_o  out  DATA_WIDTH  macro write data
- sram_be_o  out  BW  macro byte enables
- sram_rdata_i  in  DATA_WIDTH  macro read data, valid 1 cycle after req

Behaviour:
- Clock is clk_i. Reset is rst_ni: asynchronous, active-low.
- Reset values:
  - state = START, init counter = 0, RR pointer = 0.
  - rvalid_o = 0, init_done_o = 0.
  - gnt_o = 0, sram_req_o = 0 (both combinational from state).
- FSM states: START, INIT, RUN.
  - START -> INIT on the next clock if INIT_ON_RESET=1; otherwise START -> RUN.
  - INIT: each cycle assert sram_req_o=1, sram_we_o=1, sram_be_o = all ones, sram_wdata_o = 0, sram_addr_o = counter. Counter increments by 1.
  - INIT exit: when counter == NUM_WORDS-1 is written, go to RUN. Total NUM_WORDS write cycles. gnt_o = 0 throughout, even if req_i is set.
  - RUN: terminal until reset. init_done_o = 1 exactly while in RUN (registered state decode).
- Arbitration in RUN:
  - Grant the first requesting port at or after the pointer, searching upward with wrap-around.
  - gnt_o is one-hot or zero, and is in the same cycle as req_i (no extra latency).
  - The granted port's we/addr/wdata/be are muxed to the sram_* outputs. sram_req_o = |req_i.
  - On a grant to port k, the pointer becomes (k+1) mod NUM_PORTS at the clock edge. With no grant, the pointer holds.
  - NUM_PORTS = 1: grant = req_i[0]; pointer stays 0.
- Handshake:
  - A request is accepted when req_i & gnt_o in a cycle.
  - Requester holds req/we/addr/wdata/be stable until granted.
  - No request queueing; a denied requester retries next cycle.
- Response:
  - rvalid_o[k] = 1 in the cycle after every accepted request from port k, reads and writes alike.
  - rdata_o = sram_rdata_i combinationally. It is meaningful only with rvalid_o after a read; after a write it is don't-care.
  - Back-to-back grants each produce a rvalid one cycle later (full throughput, 1 access/cycle).
- Reset mid-operation (any state): outputs return to reset values immediately. An in-flight rvalid is dropped, and the init sequence restarts from address 0.
- Writes use the requester's be_i unchanged. Reads drive sram_we_o = 0, with be passed through and ignored by the macro.

Test Plan:
- Init sweep (NUM_WORDS=16, INIT_ON_RESET=1): release reset -> START 1 cycle, then 16 write cycles on addr 0..15 with wdata=0, be=0xFF; init_done_o rises on cycle 18 after release; gnt_o=0 while req_i=2'b11 throughout.
- Single read: port0 writes 0xDEADBEEF_CAFEF00D at addr 5 (be=0xFF), then reads addr 5 -> gnt_o=01 same cycle; rvalid_o=01 next cycle; rdata_o=0xDEADBEEFCAFEF00D.
- Fairness: req_i=2'b11 held for 6 cycles -> gnt_o sequence 01,10,01,10,01,10; each rvalid_o follows its grant by 1 cycle.
- Byte enable: write 0x1111..11 at addr 3, then 0xFFFF..FF with be=0x0F, read addr 3 -> 0x11111111FFFFFFFF.
- Reset mid-init: assert rst_ni low at init addr 7 -> sram_req_o=0 immediately; after release, init restarts at addr 0 and runs all 16 words.
- INIT_ON_RESET=0: after reset release, RUN after 1 cycle; init_done_o=1; a read of an unwritten addr returns macro contents unchanged.
